// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: circular FIFO of {pc, inst} pairs between ROM fetch and ID.
// First-word fall-through head, early PC stall to absorb the one ROM read in flight.
module inst_fetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [ADDR_W-1:0]          in_pc,
    input  logic [DATA_W-1:0]          in_inst,
    output logic                       in_ready,
    output logic                       pc_stall,
    output logic                       id_valid,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [DATA_W-1:0]          id_inst,
    input  logic                       id_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);

    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic          push, pop;

    logic [ADDR_W-1:0] pc_arr   [DEPTH];
    logic [DATA_W-1:0] inst_arr [DEPTH];

    // Entry storage is never cleared; validity is tracked purely by head/count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [ADDR_W-1:0] entry_pc_reg;
            logic [DATA_W-1:0] entry_inst_reg;

            always_ff @(posedge clk) begin
                if (push && (tail_reg == PW'(gi))) begin
                    entry_pc_reg   <= in_pc;
                    entry_inst_reg <= in_inst;
                end
            end

            assign pc_arr[gi]   = entry_pc_reg;
            assign inst_arr[gi] = entry_inst_reg;
        end
    endgenerate

    always_comb begin
        in_ready = (count_reg != FULL_CNT);
        id_valid = (count_reg != '0);
        push     = in_valid && in_ready && !flush;
        pop      = id_valid && id_ready && !flush;
        // Stall one entry early so the fetch already issued to ROM still has a slot.
        pc_stall = !flush && (count_reg >= STALL_CNT);
        id_pc    = id_valid ? pc_arr[head_reg]   : '0;
        id_inst  = id_valid ? inst_arr[head_reg] : '0;
        count    = count_reg;
        overflow = overflow_reg;
    end

    always_comb begin
        head_next     = head_reg;
        tail_next     = tail_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg | (in_valid & ~in_ready & ~flush);
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            // Power-of-two depth: pointer increment wraps naturally.
            if (push) tail_next = tail_reg + 1'b1;
            if (pop)  head_next = head_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer (DEPTH=4): reset, fill/overflow, full pop,
// streaming with pointer wrap, flush and mid-operation reset.
module tb_inst_fetch_buffer;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        pc_stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready;
    logic        flush;
    logic [2:0]  count;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    inst_fetch_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_pc    (in_pc),
        .in_inst  (in_inst),
        .in_ready (in_ready),
        .pc_stall (pc_stall),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_ready (id_ready),
        .flush    (flush),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        id_ready = 1'b0; flush = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_pc",    id_pc,         32'd0);
        check("rst_id_inst",  id_inst,       32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_pc_stall", 32'(pc_stall), 32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Single push, one-cycle latency to id_*
        drive_push(32'h0, 32'h11111111);
        step();
        in_valid = 1'b0;
        check("p1_id_valid", 32'(id_valid), 32'd1);
        check("p1_id_pc",    id_pc,         32'h0);
        check("p1_id_inst",  id_inst,       32'h11111111);
        check("p1_count",    32'(count),    32'd1);
        check("p1_pc_stall", 32'(pc_stall), 32'd0);

        // Fill to DEPTH
        drive_push(32'h4, 32'h22222222);
        step();
        check("p2_count",    32'(count),    32'd2);
        check("p2_pc_stall", 32'(pc_stall), 32'd0);
        drive_push(32'h8, 32'h33333333);
        step();
        check("p3_count",    32'(count),    32'd3);
        check("p3_pc_stall", 32'(pc_stall), 32'd1);
        check("p3_in_ready", 32'(in_ready), 32'd1);
        drive_push(32'hC, 32'h44444444);
        step();
        check("p4_count",    32'(count),    32'd4);
        check("p4_in_ready", 32'(in_ready), 32'd0);
        check("p4_pc_stall", 32'(pc_stall), 32'd1);

        // Fifth push while full
        drive_push(32'h10, 32'h55555555);
        step();
        check("ovf_flag",  32'(overflow), 32'd1);
        check("ovf_count", 32'(count),    32'd4);
        check("ovf_head",  id_pc,         32'h0);

        // Full with pop and push in the same cycle: pop accepted, push refused
        drive_push(32'h14, 32'h66666666);
        id_ready = 1'b1;
        #1;
        check("fullpop_head_pc", id_pc, 32'h0);
        step();
        in_valid = 1'b0;
        id_ready = 1'b0;
        check("fullpop_count",    32'(count),    32'd3);
        check("fullpop_head_pc2", id_pc,         32'h4);
        check("fullpop_head_in",  id_inst,       32'h22222222);
        check("fullpop_overflow", 32'(overflow), 32'd1);

        // pc_stall is masked combinationally while flush is high
        flush = 1'b1;
        #1;
        check("flush_stall_mask", 32'(pc_stall), 32'd0);
        flush = 1'b0;
        #1;
        check("stall_unmasked",   32'(pc_stall), 32'd1);

        // Pop to two entries, then flush with an incoming instruction
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        check("pre_flush_count", 32'(count), 32'd2);
        check("pre_flush_pc",    id_pc,      32'h8);
        flush = 1'b1;
        id_ready = 1'b1;
        drive_push(32'h18, 32'h77777777);
        step();
        flush = 1'b0;
        id_ready = 1'b0;
        in_valid = 1'b0;
        check("flush_count",    32'(count),    32'd0);
        check("flush_id_valid", 32'(id_valid), 32'd0);
        check("flush_id_pc",    id_pc,         32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        step();
        check("flush_no_ghost", 32'(id_valid), 32'd0);

        // Streaming push+pop for 10 cycles; tail wraps past index 3
        id_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_push(32'(i * 4), 32'hA0000000 + 32'(i));
            #1;
            if (i > 0) begin
                check($sformatf("stream%0d_pc", i),    id_pc,   32'((i - 1) * 4));
                check($sformatf("stream%0d_inst", i),  id_inst, 32'hA0000000 + 32'(i - 1));
                check($sformatf("stream%0d_count", i), 32'(count), 32'd1);
            end else begin
                check("stream0_empty", 32'(id_valid), 32'd0);
            end
            step();
        end
        in_valid = 1'b0;
        #1;
        check("stream_last_pc", id_pc, 32'd36);
        step();
        id_ready = 1'b0;
        check("stream_drained", 32'(count), 32'd0);

        // Three entries buffered, then reset with id_ready high
        drive_push(32'h100, 32'hC0000000);
        step();
        drive_push(32'h104, 32'hC0000001);
        step();
        drive_push(32'h108, 32'hC0000002);
        step();
        in_valid = 1'b0;
        check("prerst_count", 32'(count), 32'd3);
        rst = 1'b1;
        id_ready = 1'b1;
        step();
        rst = 1'b0;
        id_ready = 1'b0;
        check("midrst_count",    32'(count),    32'd0);
        check("midrst_id_valid", 32'(id_valid), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        drive_push(32'h200, 32'h0000BEEF);
        step();
        in_valid = 1'b0;
        check("postrst_count", 32'(count), 32'd1);
        check("postrst_pc",    id_pc,      32'h200);
        check("postrst_inst",  id_inst,    32'h0000BEEF);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        check("postrst_empty", 32'(id_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inst_fetch_buffer.md
INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of {pc, inst} entries; power of two, minimum 2.
REQ-002 Parameter ADDR_W, default 32, fetch-address width.
REQ-003 Parameter DATA_W, default 32, instruction width.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid  input  1  ROM returned a valid instruction this cycle (PC chip-enable delayed one cycle for ROM read latency).
REQ-007 in_pc  input  ADDR_W  fetch address of the instruction on in_inst.
REQ-008 in_inst  input  DATA_W  instruction word read from ROM.
REQ-009 in_ready  output  1  buffer accepts a push this cycle.
REQ-010 pc_stall  output  1  request that the PC stop advancing.
REQ-011 id_valid  output  1  head entry valid for the ID stage.
REQ-012 id_pc  output  ADDR_W  head entry address.
REQ-013 id_inst  output  DATA_W  head entry instruction.
REQ-014 id_ready  input  1  ID stage consumes the head entry this cycle.
REQ-015 flush  input  1  discard all buffered and incoming instructions (branch/jump redirect).
REQ-016 count  output  log2(DEPTH)+1  number of valid entries.
REQ-017 overflow  output  1  sticky error flag: a push was attempted while full.

Function
REQ-018 The buffer SHALL be a circular FIFO with head/tail pointers of log2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-019 Push SHALL occur when in_valid && in_ready && !flush, writing {in_pc, in_inst} at the tail and advancing the tail.
REQ-020 Pop SHALL occur when id_valid && id_ready && !flush, advancing the head.
REQ-021 in_ready SHALL be combinationally equal to (count != DEPTH).
REQ-022 id_valid SHALL be combinationally equal to (count != 0); id_pc/id_inst SHALL show the head entry with no added latency (first-word fall-through).
REQ-023 When id_valid is 0, id_pc and id_inst SHALL be 0.
REQ-024 Push-to-output latency SHALL be one cycle: an entry pushed at edge N is visible on id_* after edge N when the buffer was empty.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; when count==DEPTH, push SHALL be refused (in_ready=0) even if a pop occurs the same cycle.
REQ-026 count SHALL update as count + push - pop and never exceed DEPTH or drop below 0.
REQ-027 pc_stall SHALL be combinationally asserted when count >= DEPTH-1, so the single fetch already in flight from ROM always finds a free slot.
REQ-028 flush SHALL take priority over push and pop: on the next edge head, tail and count SHALL return to 0, and the same-cycle in_valid entry SHALL be dropped.
REQ-029 While flush is high, pc_stall SHALL be 0.
REQ-030 overflow SHALL set on the edge where in_valid && !in_ready && !flush, and SHALL remain set until rst.
REQ-031 Entry storage SHALL not be cleared by flush; only pointers and count reset.

Reset
REQ-032 While rst is high at a clock edge, head, tail and count SHALL become 0 and overflow SHALL become 0; rst SHALL take priority over flush, push and pop.
REQ-033 After reset, outputs SHALL be id_valid=0, id_pc=0, id_inst=0, in_ready=1, pc_stall=0, count=0, overflow=0.
REQ-034 Reset asserted mid-operation SHALL discard all entries, without emitting a pop on id_*, on the same edge.

Verification
REQ-035 Reset then push pc=0x0/inst=0x11111111, id_ready=0 -> next cycle id_valid=1, id_pc=0x0, id_inst=0x11111111, count=1, pc_stall=0.
REQ-036 Push 4 entries pc=0x0,0x4,0x8,0xC with id_ready=0 -> pc_stall=1 once count=3, in_ready=0 at count=4; a fifth push sets overflow=1 and count stays 4.
REQ-037 Full buffer with id_ready=1 and in_valid=1 -> pop 0x0 accepted, push refused, count=3; next cycle head id_pc=0x4.
REQ-038 Continuous push and pop for 10 cycles, pc stepping by 4 -> id_pc sequence 0x0,0x4,... in order, with no gaps after first output and tail wrapping past index 3.
REQ-039 Two entries buffered, flush=1 with in_valid=1 -> next cycle count=0, id_valid=0, id_pc=0, in_ready=1; the flushed-cycle instruction never appears.
REQ-040 Three entries buffered, rst=1 for one cycle with id_ready=1 -> count=0, id_valid=0, overflow=0; the next push appears as the only entry.
